// File: rtl/rv32_mod_decode_stage_ctrl.sv
// ---------------------------------------------------------------------------
// rv32_mod_instruction_decoder_imm
//   Immediate extraction for the decode stage. Purely combinational.
//   instruction_i : instruction bits [31:7] (opcode bits are not needed here)
//   format_i      : {i, s, s_subtype_b, u, u_subtype_j}; R-type carries no
//                   immediate, so its flag is not an input
//   immediate_o   : sign/zero-arranged 32-bit immediate, 0 when no format
// ---------------------------------------------------------------------------
module rv32_mod_instruction_decoder_imm (
    input  logic [31:7] instruction_i,
    input  logic [4:0]  format_i,
    output logic [31:0] immediate_o
);

    logic fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
    logic sgn;

    assign {fmt_i, fmt_s, fmt_b, fmt_u, fmt_j} = format_i;
    assign sgn = instruction_i[31];

    // B is flagged as S plus subtype, J as U plus subtype, so the subtype
    // flags must be tested before their parent format.
    always_comb begin
        immediate_o = '0;
        if (fmt_b) begin
            immediate_o = {{20{sgn}}, instruction_i[7], instruction_i[30:25],
                           instruction_i[11:8], 1'b0};
        end else if (fmt_s) begin
            immediate_o = {{21{sgn}}, instruction_i[30:25], instruction_i[11:7]};
        end else if (fmt_j) begin
            immediate_o = {{12{sgn}}, instruction_i[19:12], instruction_i[20],
                           instruction_i[30:21], 1'b0};
        end else if (fmt_u) begin
            immediate_o = {instruction_i[31:12], 12'h000};
        end else if (fmt_i) begin
            immediate_o = {{21{sgn}}, instruction_i[30:20]};
        end
    end

endmodule

// ---------------------------------------------------------------------------
// rv32_mod_decode_stage_ctrl
//   Decode-stage sequencer between fetch/expander and execute. Classifies the
//   incoming opcode into a format vector, buffers up to two instructions
//   (main + skid) so in_ready never depends combinationally on out_ready,
//   and drives the immediate decoder from the registered main entry.
//
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   flush_i            : drop everything buffered (redirect)
//   in_valid_i/ready_o : upstream handshake; in_ready_o = !skid_valid
//   in_instruction_i   : 32-bit uncompressed instruction
//   in_pc_i            : its PC
//   out_valid_o/ready_i: downstream handshake; out_valid_o = main_valid
//   out_instruction_o  : registered instruction
//   out_pc_o           : registered PC
//   out_format_o       : {r, i, s, s_subtype_b, u, u_subtype_j}
//   out_illegal_o      : unsupported opcode (includes bits[1:0] != 2'b11)
//   out_immediate_o    : immediate of the registered instruction
// ---------------------------------------------------------------------------
module rv32_mod_decode_stage_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_instruction_i,
    input  logic [31:0] in_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instruction_o,
    output logic [31:0] out_pc_o,
    output logic [5:0]  out_format_o,
    output logic        out_illegal_o,
    output logic [31:0] out_immediate_o
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  fmt;
        logic        illegal;
    } entry_t;

    // Encoding is {skid_valid, main_valid}; skid is only ever filled while
    // main is occupied, so 2'b10 cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_t;

    localparam logic [5:0] FMT_R    = 6'b100000;
    localparam logic [5:0] FMT_I    = 6'b010000;
    localparam logic [5:0] FMT_S    = 6'b001000;
    localparam logic [5:0] FMT_B    = 6'b001100;
    localparam logic [5:0] FMT_U    = 6'b000010;
    localparam logic [5:0] FMT_J    = 6'b000011;
    localparam logic [5:0] FMT_NONE = 6'b000000;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   in_fire, out_fire;

    // ---------------------------------------------------------------------
    // Opcode classification. Every supported opcode ends in 2'b11, so a
    // compressed-looking word falls into the default arm automatically.
    // ---------------------------------------------------------------------
    always_comb begin
        in_entry.instr = in_instruction_i;
        in_entry.pc    = in_pc_i;
        unique case (in_instruction_i[6:0])
            7'b0110011:                            in_entry.fmt = FMT_R;
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b0001111, 7'b1110011:                in_entry.fmt = FMT_I;
            7'b0100011:                            in_entry.fmt = FMT_S;
            7'b1100011:                            in_entry.fmt = FMT_B;
            7'b0110111, 7'b0010111:                in_entry.fmt = FMT_U;
            7'b1101111:                            in_entry.fmt = FMT_J;
            default:                               in_entry.fmt = FMT_NONE;
        endcase
        // Every legal format has at least one flag set.
        in_entry.illegal = (in_entry.fmt == FMT_NONE);
    end

    // Handshake: both readies derive from registered state only.
    assign in_ready_o  = (state_q != ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_o && out_ready_i;

    // ---------------------------------------------------------------------
    // Next-state / data movement. Main data is only rewritten on a load, so
    // outputs stay stable under back-pressure.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Anything offered this cycle is dropped; an out_fire this cycle
            // has already been taken by execute, nothing to undo.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (in_fire) begin
                        skid_d  = in_entry;
                        state_d = ST_TWO;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so no input can overtake skid.
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_instruction_o = main_q.instr;
    assign out_pc_o          = main_q.pc;
    assign out_format_o      = main_q.fmt;
    assign out_illegal_o     = main_q.illegal;

    rv32_mod_instruction_decoder_imm u_imm (
        .instruction_i (main_q.instr[31:7]),
        .format_i      (main_q.fmt[4:0]),
        .immediate_o   (out_immediate_o)
    );

endmodule

// File: tb/tb_rv32_mod_decode_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32_mod_decode_stage_ctrl
//   Directed scenarios followed by random traffic. The reference model is a
//   two-deep FIFO queue of {instruction, pc}; format and immediate are
//   recomputed from the RISC-V field definitions at check time.
// ---------------------------------------------------------------------------
module tb_rv32_mod_decode_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [5:0]  out_format;
    logic        out_illegal;
    logic [31:0] out_immediate;

    always #5 clk = ~clk;

    rv32_mod_decode_stage_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .in_instruction_i  (in_instruction),
        .in_pc_i           (in_pc),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_instruction_o (out_instruction),
        .out_pc_o          (out_pc),
        .out_format_o      (out_format),
        .out_illegal_o     (out_illegal),
        .out_immediate_o   (out_immediate)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ref_fmt(input logic [31:0] w);
        case (w[6:0])
            7'h33:                             return 6'b100000;
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: return 6'b010000;
            7'h23:                             return 6'b001000;
            7'h63:                             return 6'b001100;
            7'h37, 7'h17:                      return 6'b000010;
            7'h6F:                             return 6'b000011;
            default:                           return 6'b000000;
        endcase
    endfunction

    // Immediates built arithmetically from the architectural field layout.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic [5:0]  f;
        logic [31:0] s_imm;
        f     = ref_fmt(w);
        s_imm = (32'($signed(w) >>> 20) & ~32'h1F) | 32'(w[11:7]);
        case (f)
            6'b010000: return 32'($signed(w) >>> 20);
            6'b001000: return s_imm;
            // B: S layout with bit 0 moved up to bit 11
            6'b001100: return (s_imm & ~32'h801) | (32'(w[7]) << 11);
            6'b000010: return w & 32'hFFFFF000;
            6'b000011: return (32'($signed(w) >>> 11) & 32'hFFF00000)
                            | (32'(w[19:12]) << 12) | (32'(w[20]) << 11)
                            | (32'(w[30:21]) << 1);
            default:   return 32'h0;
        endcase
    endfunction

    task automatic check_outputs();
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_instruction", out_instruction, q[0].instr);
            chk("out_pc", out_pc, q[0].pc);
            chk("out_format", 32'(out_format), 32'(ref_fmt(q[0].instr)));
            chk("out_illegal", 32'(out_illegal), 32'(ref_fmt(q[0].instr) == 6'b0));
            chk("out_immediate", out_immediate, ref_imm(q[0].instr));
        end
    endtask

    // Called just after a falling edge: check, drive, clock, update model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl, input logic rs);
        logic rdy_m;
        ent_t e;
        check_outputs();
        rdy_m          = (q.size() < 2);
        in_valid       = v;
        in_instruction = ins;
        in_pc          = pc;
        out_ready      = ordy;
        flush          = fl;
        rst            = rs;
        @(posedge clk);
        if (rs || fl) begin
            q.delete();
        end else begin
            if (ordy && q.size() > 0) void'(q.pop_front());
            if (v && rdy_m) begin
                e.instr = ins;
                e.pc    = pc;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[13] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                                 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h10};
        logic [31:0] w;
        w      = $urandom;
        w[6:0] = ops[$urandom_range(0, 12)];
        if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom_range(0, 2));
        return w;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_instruction = 32'h00500093; in_pc = 32'h0;

        // Reset with a live handshake on the input
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_in_ready", 32'(in_ready), 32'h1);
            chk("rst_out_instruction", out_instruction, 32'h0);
            chk("rst_out_pc", out_pc, 32'h0);
            chk("rst_out_format", 32'(out_format), 32'h0);
            chk("rst_out_illegal", 32'(out_illegal), 32'h0);
            chk("rst_out_immediate", out_immediate, 32'h0);
        end
        q.delete();

        // Streaming: ADDI then BEQ back-to-back
        cycle(1'b1, 32'h00500093, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("addi_imm", out_immediate, 32'h5);
        chk("addi_fmt", 32'(out_format), 32'b010000);
        cycle(1'b1, 32'hFE000EE3, 32'h4, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Back-pressure: LUI then JAL, third offer refused while full
        cycle(1'b1, 32'h123450B7, 32'h8, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h008000EF, 32'hC, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready_low", 32'(in_ready), 32'h0);
        cycle(1'b1, 32'h00000013, 32'h10, 1'b0, 1'b0, 1'b0);
        chk("lui_imm", out_immediate, 32'h12345000);
        chk("lui_fmt", 32'(out_format), 32'b000010);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("jal_imm", out_immediate, 32'h8);
        chk("jal_fmt", 32'(out_format), 32'b000011);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Illegal encodings and a store
        cycle(1'b1, 32'h0000FFFF, 32'h20, 1'b1, 1'b0, 1'b0);
        chk("ill1_flag", 32'(out_illegal), 32'h1);
        cycle(1'b1, 32'h00000010, 32'h24, 1'b1, 1'b0, 1'b0);
        chk("ill2_flag", 32'(out_illegal), 32'h1);
        cycle(1'b1, 32'h00112623, 32'h28, 1'b1, 1'b0, 1'b0);
        chk("sw_imm", out_immediate, 32'hC);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush while full with a new offer in the same cycle
        cycle(1'b1, 32'h00100093, 32'h30, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 32'h34, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300093, 32'h38, 1'b0, 1'b1, 1'b0);
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        chk("flush_in_ready", 32'(in_ready), 32'h1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush together with out_fire
        cycle(1'b1, 32'h00400093, 32'h40, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00500093, 32'h44, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush and reset together
        cycle(1'b1, 32'h00600093, 32'h50, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h00700093, 32'h54, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) != 0), rand_instr(), $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0),
                  ($urandom_range(0, 200) == 0));
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
